ring_decoder: RTL and testbench

RING_DECODER -- requirements
Module: ring_decoder

---
 rtl/ring_decoder.sv | 143 ++++++++++++++
 tb/tb_ring_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
// Lock/fault tracker for a rotate-left one-hot ring counter: decodes the phase,
// counts revolutions while locked and flags sequence faults.
module ring_decoder #(
  parameter int STATE_WIDTH = 3,
  parameter int LOCK_CYCLES = 4,
  parameter int LAP_W       = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [STATE_WIDTH-1:0]         states,
  input  logic                           err_clr,
  output logic [$clog2(STATE_WIDTH)-1:0] phase,
  output logic                           locked,
  output logic                           err,
  output logic                           err_sticky,
  output logic                           lap_tick,
  output logic [LAP_W-1:0]               lap_count
);

  localparam int PW    = $clog2(STATE_WIDTH);
  localparam int RUN_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [RUN_W-1:0]       r_run;
  logic [STATE_WIDTH-1:0] r_s;
  logic [STATE_WIDTH-1:0] r_p;
  logic [PW-1:0]          r_phase;
  logic                   r_err;
  logic                   r_err_sticky;
  logic                   r_lap_tick;
  logic [LAP_W-1:0]       r_lap_count;

  state_t                 w_next_state;
  logic [RUN_W-1:0]       w_next_run;
  logic [STATE_WIDTH-1:0] w_rot;
  logic [PW-1:0]          w_idx;
  logic                   w_valid;
  logic                   w_correct;
  logic                   w_fault_entry;
  logic                   w_lap_event;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_valid   = (r_s != '0) && ((r_s & (r_s - STATE_WIDTH'(1))) == '0);
  assign w_rot     = {r_p[STATE_WIDTH-2:0], r_p[STATE_WIDTH-1]};
  assign w_correct = w_valid && (r_s == w_rot);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < STATE_WIDTH; i++) begin
      if (r_s[i]) w_idx = PW'(i);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_next_run    = r_run;
    w_fault_entry = 1'b0;
    w_lap_event   = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_valid) begin
          w_next_state = SYNC;
          w_next_run   = '0;
        end
      end
      SYNC: begin
        if (!w_valid) begin
          w_next_state = HUNT;
          w_next_run   = '0;
        end else if (w_correct) begin
          if (r_run >= RUN_W'(LOCK_CYCLES - 1)) begin
            w_next_state = LOCKED;
            w_next_run   = RUN_W'(LOCK_CYCLES);
          end else begin
            w_next_run = r_run + RUN_W'(1);
          end
        end else begin
          w_next_run = '0;
        end
      end
      LOCKED: begin
        if (w_correct) begin
          w_lap_event = r_p[STATE_WIDTH-1] & r_s[0];
        end else begin
          w_next_state  = FAULT;
          w_next_run    = '0;
          w_fault_entry = 1'b1;
        end
      end
      FAULT: begin
        w_next_state = HUNT;
        w_next_run   = '0;
      end
      default: begin
        w_next_state = HUNT;
        w_next_run   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= HUNT;
      r_run        <= '0;
      r_s          <= '0;
      r_p          <= '0;
      r_phase      <= '0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_lap_tick   <= 1'b0;
      r_lap_count  <= '0;
    end else begin
      r_s        <= states;
      r_p        <= r_s;
      r_state    <= w_next_state;
      r_run      <= w_next_run;
      r_err      <= w_fault_entry;
      r_lap_tick <= w_lap_event;
      if (w_valid) r_phase <= w_idx;
      // A new fault outranks a simultaneous clear.
      if (w_fault_entry)  r_err_sticky <= 1'b1;
      else if (err_clr)   r_err_sticky <= 1'b0;
      if (w_lap_event) r_lap_count <= r_lap_count + LAP_W'(1);
    end
  end

  assign phase      = r_phase;
  assign locked     = (r_state == LOCKED);
  assign err        = r_err;
  assign err_sticky = r_err_sticky;
  assign lap_tick   = r_lap_tick;
  assign lap_count  = r_lap_count;

endmodule

// File: tb/tb_ring_decoder.sv
// Bench for ring_decoder (3-bit ring, lock after 4, 8-bit laps): directed scenarios
// plus randomized traffic against a cycle-level behavioural model.
module tb_ring_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] states = 3'b000;
  logic       err_clr = 1'b0;
  logic [1:0] phase;
  logic       locked;
  logic       err;
  logic       err_sticky;
  logic       lap_tick;
  logic [7:0] lap_count;

  ring_decoder #(.STATE_WIDTH(3), .LOCK_CYCLES(4), .LAP_W(8)) dut (
    .clk(clk), .rst(rst), .states(states), .err_clr(err_clr),
    .phase(phase), .locked(locked), .err(err), .err_sticky(err_sticky),
    .lap_tick(lap_tick), .lap_count(lap_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] ring [3] = '{3'b001, 3'b010, 3'b100};
  int pos = 0;

  logic [13:0] dut_vec;
  assign dut_vec = {phase, locked, err, err_sticky, lap_tick, lap_count};

  // Behavioural model: samples kept as integers, rotation by arithmetic.
  localparam int M_HUNT = 0, M_SYNC = 1, M_LOCKED = 2, M_FAULT = 3;
  int m_s, m_p, m_mode, m_run, m_phase, m_laps;
  bit m_err, m_sticky, m_tick;

  function automatic int rotl3(int p);
    return ((p * 2) % 8) + (p / 4);
  endfunction

  function automatic bit onehot(int s);
    return (s == 1) || (s == 2) || (s == 4);
  endfunction

  function automatic int idx_of(int s);
    for (int i = 0; i < 3; i++) if (s == (1 << i)) return i;
    return 0;
  endfunction

  function automatic bit m_faults_now();
    return (m_mode == M_LOCKED) && !(onehot(m_s) && m_s == rotl3(m_p));
  endfunction

  function automatic void model_edge(int x, bit clr, bit r);
    bit valid, correct;
    if (!r) begin
      m_s = 0; m_p = 0; m_mode = M_HUNT; m_run = 0; m_phase = 0; m_laps = 0;
      m_err = 0; m_sticky = 0; m_tick = 0;
      return;
    end
    valid   = onehot(m_s);
    correct = valid && (m_s == rotl3(m_p));
    m_err  = 0;
    m_tick = 0;
    case (m_mode)
      M_HUNT:   if (valid) begin m_mode = M_SYNC; m_run = 0; end
      M_SYNC: begin
        if (!valid) begin m_mode = M_HUNT; m_run = 0; end
        else if (correct) begin
          m_run = (m_run + 1 > 4) ? 4 : m_run + 1;
          if (m_run == 4) m_mode = M_LOCKED;
        end else m_run = 0;
      end
      M_LOCKED: begin
        if (correct) begin
          if (m_p == 4 && m_s == 1) begin m_tick = 1; m_laps = (m_laps + 1) % 256; end
        end else begin m_mode = M_FAULT; m_err = 1; m_run = 0; end
      end
      default:  begin m_mode = M_HUNT; m_run = 0; end
    endcase
    if (valid) m_phase = idx_of(m_s);
    if (m_err) m_sticky = 1;
    else if (clr) m_sticky = 0;
    m_p = m_s;
    m_s = x;
  endfunction

  function automatic logic [13:0] exp_vec();
    return {2'(m_phase), (m_mode == M_LOCKED), m_err, m_sticky, m_tick, 8'(m_laps)};
  endfunction

  task automatic step(input logic [2:0] x, input logic clr, input logic r);
    states = x; err_clr = clr; rst = r;
    @(posedge clk);
    model_edge(int'(x), clr, r);
    #1;
  endtask

  task automatic do_reset();
    step(3'b000, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    pos = 0;
  endtask

  task automatic ring_step(input logic clr);
    step(ring[pos], clr, 1'b1);
    pos = (pos + 1) % 3;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(3'($urandom), 1'($urandom), 1'b0);
      n_cmp++;
      if (dut_vec !== 14'h0) begin
        n_bad++; $display("FAIL reset_state k=%0d got=%h exp=%h", k, dut_vec, 14'h0);
      end
    end
    pos = 0;
  endtask

  task automatic test_lock_acquire();
    for (int k = 1; k <= 12; k++) begin
      ring_step(1'b0);
      n_cmp++;
      if (locked !== (k >= 6)) begin
        n_bad++; $display("FAIL lock_edge k=%0d got=%b exp=%b", k, locked, (k >= 6));
      end
      if (k >= 2) begin
        n_cmp++;
        if (phase !== 2'((k - 2) % 3)) begin
          n_bad++; $display("FAIL phase_latency k=%0d got=%0d exp=%0d", k, phase, (k - 2) % 3);
        end
      end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL lock_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_laps();
    int ticks = 0;
    do_reset();
    for (int k = 0; k < 6; k++) ring_step(1'b0);
    for (int k = 0; k < 9; k++) begin
      ring_step(1'b0);
      if (lap_tick) ticks++;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL laps_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (ticks != 3 || lap_count !== 8'd3) begin
      n_bad++; $display("FAIL laps_count ticks=%0d count=%0d exp=3/3", ticks, lap_count);
    end
  endtask

  task automatic test_skip_fault();
    int err_cycles = 0;
    bit dropped = 0;
    // Locked from the previous scenario; jump two positions instead of one.
    step(ring[pos], 1'b0, 1'b1);
    pos = (pos + 2) % 3;
    for (int k = 0; k < 14; k++) begin
      ring_step(1'b0);
      if (err) err_cycles++;
      if (!locked) dropped = 1;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL skip_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (err_cycles != 1 || !dropped || err_sticky !== 1'b1 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL skip_summary err_cycles=%0d dropped=%0d sticky=%b locked=%b exp=1/1/1/1",
               err_cycles, dropped, err_sticky, locked);
    end
  endtask

  task automatic test_invalid_in_sync();
    do_reset();
    ring_step(1'b0);
    ring_step(1'b0);
    step(3'b011, 1'b0, 1'b1);
    step(3'b100, 1'b0, 1'b1);
    n_cmp++;
    if (phase !== 2'd1 || err !== 1'b0 || locked !== 1'b0) begin
      n_bad++; $display("FAIL sync_invalid phase=%0d err=%b locked=%b exp=1/0/0", phase, err, locked);
    end
    pos = 0;
    for (int k = 0; k < 10; k++) begin
      ring_step(1'b0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL sync_invalid_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_err_clr_same_cycle();
    bit seen = 0;
    do_reset();
    for (int k = 0; k < 7; k++) ring_step(1'b0);
    step(ring[pos], 1'b0, 1'b1);
    pos = (pos + 2) % 3;
    for (int k = 0; k < 6 && !seen; k++) begin
      if (m_faults_now()) begin
        ring_step(1'b1);
        seen = 1;
        n_cmp++;
        if (err !== 1'b1 || err_sticky !== 1'b1) begin
          n_bad++; $display("FAIL clr_collide err=%b sticky=%b exp=1/1", err, err_sticky);
        end
      end else ring_step(1'b0);
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL clr_collide_timeout got=no_fault exp=fault");
    end
    ring_step(1'b1);
    n_cmp++;
    if (err_sticky !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL clr_alone sticky=%b err=%b exp=0/0", err_sticky, err);
    end
  endtask

  task automatic test_lap_wrap();
    int errs = 0;
    bit wrapped = 0;
    do_reset();
    for (int k = 0; k < 900 && m_laps != 255; k++) begin
      ring_step(1'b0);
      if (err) errs++;
    end
    n_cmp++;
    if (lap_count !== 8'd255 || errs != 0) begin
      n_bad++; $display("FAIL wrap_preload count=%0d errs=%0d exp=255/0", lap_count, errs);
    end
    for (int k = 0; k < 4 && !wrapped; k++) begin
      ring_step(1'b0);
      if (m_tick) wrapped = 1;
    end
    n_cmp++;
    if (!wrapped || lap_count !== 8'd0 || err !== 1'b0 || lap_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_zero count=%0d err=%b tick=%b exp=0/0/1", lap_count, err, lap_tick);
    end
    ring_step(1'b0);
    step(ring[pos], 1'b1, 1'b0);
    n_cmp++;
    if (dut_vec !== 14'h0) begin
      n_bad++; $display("FAIL reset_mid_lap got=%h exp=%h", dut_vec, 14'h0);
    end
  endtask

  task automatic test_random();
    logic [2:0] x = 3'b001;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(9) < 8) begin
        if (!onehot(int'(x))) x = ring[$urandom_range(2)];
        else x = {x[1:0], x[2]};
      end else x = 3'($urandom);
      step(x, ($urandom_range(7) == 0), ($urandom_range(199) != 0));
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL random_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_edge(0, 1'b0, 1'b0);
    test_reset();
    test_lock_acquire();
    test_laps();
    test_skip_fault();
    test_invalid_in_sync();
    test_err_clr_same_cycle();
    test_lap_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
